inv_mod_sched: RTL and testbench
================================

// Module: inv_mod_sched
// PURPOSE
//   Round-robin scheduler sharing one modular-inverse core among N_REQ SM2 clients.
//   Example clients: signer s=(1+d)^-1 mod n; Jacobian->affine Z^-1 mod p.
//   Accepts one request at a time and latches its operand and modulus.
//   Launches the core, captures the result and returns it to the granted client, tagged by index.
//   Sits between the sm2_signature datapath blocks and the single inverse core.
// PARAMETERS
//   N_REQ    2     number of requesters (2..8)
//   WIDTH    256   operand/modulus width in bits
//   TIMEOUT  8191  max WAIT cycles before abort (core worst case < 4200 at 256 b)
// PORTS
//   clk        in   1            single clock, rising edge
//   rst        in   1            synchronous active-high reset
//   req_valid  in   N_REQ        request pending, one bit per client
//   req_ready  out  N_REQ        one-hot acceptance; operand is taken when valid&ready
//   req_a      in   N_REQ*WIDTH  operand to invert; client i uses slice [i*WIDTH +: WIDTH]
//   req_p      in   N_REQ*WIDTH  odd modulus p or n, same slicing as req_a
//   rsp_valid  out  N_REQ        one-cycle one-hot pulse to the owner of the result
//   rsp_b      out  WIDTH        result a^-1 mod p, valid with rsp_valid
//   rsp_err    out  1            with rsp_valid: a==0 or timeout; rsp_b=0 in that case
//   busy       out  1            high in any state other than IDLE
//   inv_start  out  1            one-cycle launch pulse to the core
//   inv_a      out  WIDTH        latched operand, held stable from START to RESP
//   inv_p      out  WIDTH        latched modulus, held stable from START to RESP
//   inv_done   in   1            core finished; held high until the next inv_start
//   inv_b      in   WIDTH        core result, valid while inv_done
// BEHAVIOUR
//   Reset values: req_ready=0, rsp_valid=0, rsp_b=0, rsp_err=0, busy=0, inv_start=0,
//     inv_a=0, inv_p=0, rr_ptr=0, state=IDLE.
//   FSM states: IDLE, START, WAIT, RESP.
//   IDLE:
//     - If any req_valid is set, winner g = first set bit at or after rr_ptr, searching cyclically.
//     - req_ready[g]=1 combinationally in that cycle; req_a[g] and req_p[g] are latched; gnt=g.
//     - If the latched a==0, go straight to RESP with err=1 and do not launch the core.
//     - Otherwise go to START.
//   START: inv_start=1 for exactly one cycle; timeout counter cleared -> WAIT.
//   WAIT:
//     - If inv_done=1, capture inv_b -> RESP with err=0.
//     - Else if counter==TIMEOUT -> RESP with err=1 and rsp_b=0.
//     - Else counter increments.
//   RESP:
//     - rsp_valid[gnt]=1 for one cycle; rsp_b and rsp_err are registered.
//     - rr_ptr = (gnt+1) mod N_REQ -> IDLE.
//   Latency: valid seen at cycle t gives rsp_valid at t+3+core_latency.
//     a==0 gives rsp_valid at t+1.
//   Throughput: next grant at the earliest in the cycle after RESP.
//   Fairness: the client just served has the lowest priority on the next arbitration.
//   Responses have no backpressure; clients must sample them on the pulse.
//   Clients hold req_valid and operands until ready; dropping valid before ready is legal and ignored.
//   A request raised while busy waits in place; req_ready stays 0 outside IDLE.
//   inv_done already high on entering WAIT (stale from a prior job) is not possible:
//     the core clears done on inv_start, so WAIT samples inv_done from the cycle after START.
//   Modulus is not checked for oddness; an even p is the client's error and the core result is undefined.
//   rsp_b is WIDTH bits with no reduction; the core returns a value < p.
//   rst in any state: return to IDLE next cycle and drop the in-flight job with no rsp pulse.
//     inv_start deasserts; the core must be reset with the same rst.
// STRUCTURE
//   sm2_pkg:
//     - WIDTH default constant.
//     - SM2 p and n constants.
//     - sched_state_t encoding (IDLE=0, START=1, WAIT=2, RESP=3).
//     - clog2 helper function.
//   Sub-module rr_arbiter: combinational rotate-priority-rotate back.
//     - Inputs: req[N_REQ], ptr.
//     - Outputs: one-hot gnt and binary index.
//     - Reused later by the shared modular-multiplier scheduler.
//   Everything else (FSM, operand latches, timeout counter) lives in inv_mod_sched.
// TESTING (bench pairs the scheduler with the real inverse core, p = SM2 prime)
//   1 Single client, a=3, p=7: req_ready at cycle t, inv_start at t+1,
//     rsp_valid[0] with rsp_b=5, rsp_err=0.
//   2 Clients 0 and 1 both valid from reset (a=3/p=7 and a=2/p=11):
//     0 is served first (rsp_b=5), then 1 (rsp_b=6); a third round serves 0 first again.
//   3 a=0 on client 1: rsp_valid[1] at t+1 with rsp_err=1, rsp_b=0, and inv_start never pulses.
//   4 Stub core with inv_done tied low: after TIMEOUT WAIT cycles, rsp_err=1 and busy drops;
//     the next request is served normally.
//   5 rst asserted mid-WAIT: no rsp_valid pulse; all outputs at reset values next cycle;
//     a fresh request completes correctly.
//   6 Random 256-bit a with p = SM2 p and with n, 500 jobs from 2 clients:
//     a*rsp_b mod p == 1 for every job; no lost or duplicated responses.

Source files
------------

// File: rtl/sm2_pkg.sv
// sm2_pkg: shared SM2 constants, scheduler state encoding and width helper.
package sm2_pkg;
  localparam int WIDTH_DEF = 256;
  localparam logic [255:0] SM2_P = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [255:0] SM2_N = 256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF7203DF6B21C6052B53BBF40939D54123;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} sched_state_t;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, first request at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  localparam logic [PW:0] NW = (PW+1)'(N);
  logic [2*N-1:0] dbl;
  logic [PW-1:0]  ri;
  logic [PW:0]    sum;
  always_comb begin
    dbl = {req, req} >> ptr;
    ri = '0;
    for (int i = N - 1; i >= 0; i--) if (dbl[i]) ri = PW'(i);
    sum = {1'b0, ri} + {1'b0, ptr};
    idx = sum >= NW ? PW'(sum - NW) : PW'(sum);
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/inv_mod_sched.sv
// inv_mod_sched: round-robin scheduler sharing one modular-inverse core among N_REQ clients.
module inv_mod_sched
  import sm2_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 8191
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_p,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_b,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   inv_start,
  output logic [WIDTH-1:0]       inv_a,
  output logic [WIDTH-1:0]       inv_p,
  input  logic                   inv_done,
  input  logic [WIDTH-1:0]       inv_b
);
  localparam int PW = clog2(N_REQ);
  localparam int CW = clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  sched_state_t state;
  logic [PW-1:0] rr_ptr, gnt, arb_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sel, p_sel;
  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );
  assign a_sel = req_a[arb_idx*WIDTH +: WIDTH];
  assign p_sel = req_p[arb_idx*WIDTH +: WIDTH];
  assign req_ready = state == IDLE ? arb_gnt : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      cnt       <= '0;
      inv_start <= 1'b0;
      inv_a     <= '0;
      inv_p     <= '0;
      rsp_valid <= '0;
      rsp_b     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      inv_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: if (|req_valid) begin
          inv_a <= a_sel;
          inv_p <= p_sel;
          gnt   <= arb_idx;
          // a zero operand has no inverse, so answer it without touching the core
          if (a_sel == '0) begin
            rsp_err   <= 1'b1;
            rsp_b     <= '0;
            rsp_valid <= N_REQ'(1) << arb_idx;
            state     <= RESP;
          end else begin
            inv_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (inv_done) begin
          rsp_b     <= inv_b;
          rsp_err   <= 1'b0;
          rsp_valid <= N_REQ'(1) << gnt;
          state     <= RESP;
        end else if (cnt == TO) begin
          rsp_b     <= '0;
          rsp_err   <= 1'b1;
          rsp_valid <= N_REQ'(1) << gnt;
          state     <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: begin
          rr_ptr <= gnt == LAST ? '0 : gnt + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_mod_sched.sv
// tb_inv_mod_sched: scoreboard bench with a behavioural inverse core and random SM2 jobs.
module tb_inv_mod_sched;
  import sm2_pkg::*;
  localparam int W = 256;
  localparam int TO = 100;
  typedef struct {int c; logic [W-1:0] a; logic [W-1:0] p; logic err;} job_t;
  logic clk = 0, rst = 1;
  logic [1:0] req_valid = '0, req_ready, rsp_valid;
  logic [2*W-1:0] req_a = '0, req_p = '0;
  logic [W-1:0] rsp_b, inv_a, inv_p, inv_b;
  logic rsp_err, busy, inv_start, inv_done;
  logic hang = 0, active;
  int lat_cnt;
  int cyc = 0, checks = 0, passed = 0;
  int acc_cyc, start_cyc, rsp_cyc, n_start = 0, n_rsp = 0;
  logic [W-1:0] acc_a, last_b;
  job_t q[$];
  int order[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_mod_sched #(.N_REQ(2), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_p(req_p), .rsp_valid(rsp_valid), .rsp_b(rsp_b),
    .rsp_err(rsp_err), .busy(busy), .inv_start(inv_start), .inv_a(inv_a),
    .inv_p(inv_p), .inv_done(inv_done), .inv_b(inv_b)
  );

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, b, p);
    logic [2*W-1:0] t;
    t = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) % {{W{1'b0}}, p};
    return t[W-1:0];
  endfunction

  // Fermat inverse: all moduli used here are prime
  function automatic logic [W-1:0] modinv(input logic [W-1:0] a, p);
    logic [W-1:0] e, r, x;
    e = p - 2;
    r = 1;
    x = a % p;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = mulmod(r, x, p);
      x = mulmod(x, x, p);
    end
    return r;
  endfunction

  function automatic void chk(input logic ok, input string nm, input logic [W-1:0] act, exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  always @(posedge clk)
    if (rst) begin
      inv_done <= 0;
      active   <= 0;
      inv_b    <= '0;
      lat_cnt  <= 0;
    end else if (inv_start) begin
      inv_done <= 0;
      active   <= 1;
      lat_cnt  <= $urandom_range(0, 4);
    end else if (active && !hang) begin
      if (lat_cnt == 0) begin
        inv_done <= 1;
        active   <= 0;
        inv_b    <= modinv(inv_a, inv_p);
      end else lat_cnt <= lat_cnt - 1;
    end

  always @(negedge clk) begin
    int f, idx;
    job_t e;
    if (!rst) begin
      if (rsp_valid != 0) begin
        n_rsp++;
        rsp_cyc = cyc;
        last_b = rsp_b;
        idx = rsp_valid[1] ? 1 : 0;
        order.push_back(idx);
        chk($onehot(rsp_valid), "rsp_onehot", W'(rsp_valid), 1);
        f = -1;
        for (int k = 0; k < q.size(); k++) if (f < 0 && q[k].c == idx) f = k;
        if (f < 0) chk(0, "unexpected_rsp", W'(idx), 0);
        else begin
          e = q[f];
          q.delete(f);
          if (e.err) begin
            chk(rsp_err == 1, "rsp_err_set", W'(rsp_err), 1);
            chk(rsp_b == 0, "rsp_b_zero", rsp_b, 0);
          end else begin
            chk(rsp_err == 0, "rsp_err_clr", W'(rsp_err), 0);
            chk(rsp_b < e.p && mulmod(e.a, rsp_b, e.p) == 1, "inverse", mulmod(e.a, rsp_b, e.p), 1);
          end
        end
      end
      if (inv_start) begin
        n_start++;
        start_cyc = cyc;
        chk(inv_a == acc_a, "inv_a_latched", inv_a, acc_a);
      end
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i]) begin
          q.push_back('{i, req_a[i*W +: W], req_p[i*W +: W], req_a[i*W +: W] == 0 || hang});
          acc_cyc = cyc;
          acc_a = req_a[i*W +: W];
        end
    end
  end

  task automatic issue(input int i, input logic [W-1:0] a, p);
    logic got;
    @(posedge clk); #1;
    req_valid[i] = 1;
    req_a[i*W +: W] = a;
    req_p[i*W +: W] = p;
    got = 0;
    for (int k = 0; k < 20000 && !got; k++) begin
      @(negedge clk);
      got = req_ready[i];
    end
    if (!got) chk(0, "accept_timeout", W'(i), 1);
    @(posedge clk); #1;
    req_valid[i] = 0;
  endtask

  task automatic drain();
    logic ok;
    ok = 0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      ok = q.size() == 0 && !busy;
    end
    if (!ok) chk(0, "drain_timeout", W'(q.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk(req_ready == 0 && rsp_valid == 0 && !rsp_err && !busy && !inv_start, "reset_ctrl",
        W'({req_ready, rsp_valid, rsp_err, busy, inv_start}), 0);
    chk(rsp_b == 0 && inv_a == 0 && inv_p == 0, "reset_data", rsp_b | inv_a | inv_p, 0);
    rst = 0;
    q.delete();
    order.delete();
  endtask

  task automatic client_loop(input int i, input int n);
    logic [W-1:0] a, p;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < 8; k++) a[k*32 +: 32] = $urandom;
      p = $urandom_range(0, 1) ? SM2_P : SM2_N;
      a = a % p;
      issue(i, a, p);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
  endtask

  initial begin
    int n0;
    do_reset();
    issue(0, 3, 7);
    drain();
    chk(start_cyc == acc_cyc + 1, "start_latency", W'(start_cyc - acc_cyc), 1);
    chk(last_b == 5, "inv_3_mod_7", last_b, 5);
    do_reset();
    fork
      issue(0, 3, 7);
      issue(1, 2, 11);
    join
    fork
      issue(0, 3, 7);
      issue(1, 2, 11);
    join
    drain();
    chk(order.size() == 4 && order[0] == 0 && order[1] == 1 && order[2] == 0 && order[3] == 1,
        "rr_order", W'(order.size() == 4 ? {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0]} : 16'hFFFF), 16'h0101);
    n0 = n_start;
    issue(1, 0, 11);
    drain();
    chk(rsp_cyc == acc_cyc + 1, "zero_latency", W'(rsp_cyc - acc_cyc), 1);
    chk(n_start == n0, "zero_no_start", W'(n_start - n0), 0);
    chk(order[order.size()-1] == 1, "zero_owner", W'(order[order.size()-1]), 1);
    hang = 1;
    issue(0, 3, 7);
    drain();
    chk(rsp_cyc - start_cyc == TO + 2, "timeout_len", W'(rsp_cyc - start_cyc), W'(TO + 2));
    hang = 0;
    issue(1, 2, 11);
    drain();
    chk(last_b == 6, "after_timeout", last_b, 6);
    hang = 1;
    issue(1, 3, 7);
    repeat (5) @(posedge clk);
    n0 = n_rsp;
    do_reset();
    repeat (3) @(negedge clk);
    chk(n_rsp == n0, "no_rsp_on_reset", W'(n_rsp - n0), 0);
    hang = 0;
    issue(1, 3, 7);
    drain();
    chk(last_b == 5, "after_reset", last_b, 5);
    do_reset();
    n0 = n_rsp;
    fork
      client_loop(0, 250);
      client_loop(1, 250);
    join
    drain();
    chk(n_rsp - n0 == 500, "rsp_count", W'(n_rsp - n0), 500);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
